// File: rtl/store_queue.sv
// In-order store reservation queue: captures operands at issue or from the CDB,
// forms base+offset addresses and offers resolved stores to memory in program order.
module store_queue #(
  parameter int WORD_SIZE = 32,
  parameter int RB_INDEX  = 4,
  parameter int RB_SIZE   = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [RB_INDEX-1:0]         issue_rb_index,
  input  logic [WORD_SIZE-1:0]        issue_base_v,
  input  logic [RB_INDEX-1:0]         issue_base_q,
  input  logic                        issue_base_rdy,
  input  logic [WORD_SIZE-1:0]        issue_data_v,
  input  logic [RB_INDEX-1:0]         issue_data_q,
  input  logic                        issue_data_rdy,
  input  logic [WORD_SIZE-1:0]        issue_offset,
  input  logic [WORD_SIZE*RB_SIZE-1:0] cdb_data,
  input  logic [RB_SIZE-1:0]          cdb_valid,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [WORD_SIZE-1:0]        mem_req_addr,
  output logic [WORD_SIZE-1:0]        mem_req_data,
  output logic [RB_INDEX-1:0]         mem_req_rb_index,
  output logic [CNT_W-1:0]            count,
  output logic                        empty
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [RB_INDEX-1:0]  tag_t;

  typedef struct packed {
    logic  busy;
    tag_t  rb;
    word_t base_v;
    tag_t  base_t;
    logic  base_rdy;
    word_t data_v;
    tag_t  data_t;
    logic  data_rdy;
    word_t off;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  word_t cdb_w [RB_SIZE];
  ent_t  head_e;
  ent_t  new_e;
  logic  alloc;
  logic  retire;

  for (genvar k = 0; k < RB_SIZE; k++) begin : g_cdb
    assign cdb_w[k] =
      cdb_data[k*WORD_SIZE +: WORD_SIZE];
  end

  assign head_e      = ent_q[head_q];
  assign issue_ready = (cnt_q != CNT_W'(DEPTH));
  assign empty       = (cnt_q == '0);
  assign count       = cnt_q;

  assign mem_req_valid = head_e.busy
                       & head_e.base_rdy
                       & head_e.data_rdy;

  assign mem_req_addr = mem_req_valid
    ? head_e.base_v + head_e.off : '0;
  assign mem_req_data = mem_req_valid
    ? head_e.data_v : '0;
  assign mem_req_rb_index = mem_req_valid
    ? head_e.rb : '0;

  // Flush wins over both sides of the handshake.
  assign alloc  = issue_valid & issue_ready & ~flush;
  assign retire = mem_req_valid & mem_req_ready & ~flush;

  always_comb begin
    new_e      = '0;
    new_e.busy = 1'b1;
    new_e.rb   = issue_rb_index;
    new_e.off  = issue_offset;

    if (issue_base_rdy) begin
      new_e.base_v   = issue_base_v;
      new_e.base_rdy = 1'b1;
    end else if (cdb_valid[issue_base_q]) begin
      new_e.base_v   = cdb_w[issue_base_q];
      new_e.base_rdy = 1'b1;
    end else begin
      new_e.base_t = issue_base_q;
    end

    if (issue_data_rdy) begin
      new_e.data_v   = issue_data_v;
      new_e.data_rdy = 1'b1;
    end else if (cdb_valid[issue_data_q]) begin
      new_e.data_v   = cdb_w[issue_data_q];
      new_e.data_rdy = 1'b1;
    end else begin
      new_e.data_t = issue_data_q;
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;

    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        if (!ent_q[i].base_rdy &&
            cdb_valid[ent_q[i].base_t]) begin
          ent_d[i].base_v   = cdb_w[ent_q[i].base_t];
          ent_d[i].base_rdy = 1'b1;
        end
        if (!ent_q[i].data_rdy &&
            cdb_valid[ent_q[i].data_t]) begin
          ent_d[i].data_v   = cdb_w[ent_q[i].data_t];
          ent_d[i].data_rdy = 1'b1;
        end
      end
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].busy = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (alloc) begin
        ent_d[tail_q] = new_e;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (retire) begin
        ent_d[head_q].busy = 1'b0;
        head_d             = head_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(alloc)
                    - CNT_W'(retire);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: queue-based reference model compared every
// cycle, plus literal expectations for the listed scenarios.
module tb_store_queue;

  localparam int W  = 32;
  localparam int RI = 4;
  localparam int RS = 16;
  localparam int D  = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            issue_valid = 1'b0;
  logic            issue_ready;
  logic [RI-1:0]   issue_rb_index = '0;
  logic [W-1:0]    issue_base_v = '0;
  logic [RI-1:0]   issue_base_q = '0;
  logic            issue_base_rdy = 1'b0;
  logic [W-1:0]    issue_data_v = '0;
  logic [RI-1:0]   issue_data_q = '0;
  logic            issue_data_rdy = 1'b0;
  logic [W-1:0]    issue_offset = '0;
  logic [W*RS-1:0] cdb_data = '0;
  logic [RS-1:0]   cdb_valid = '0;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic [W-1:0]    mem_req_addr;
  logic [W-1:0]    mem_req_data;
  logic [RI-1:0]   mem_req_rb_index;
  logic [CW-1:0]   count;
  logic            empty;

  int checks = 0;
  int errors = 0;

  store_queue #(
    .WORD_SIZE(W), .RB_INDEX(RI), .RB_SIZE(RS),
    .DEPTH(D), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_rb_index(issue_rb_index),
    .issue_base_v(issue_base_v),
    .issue_base_q(issue_base_q),
    .issue_base_rdy(issue_base_rdy),
    .issue_data_v(issue_data_v),
    .issue_data_q(issue_data_q),
    .issue_data_rdy(issue_data_rdy),
    .issue_offset(issue_offset),
    .cdb_data(cdb_data),
    .cdb_valid(cdb_valid),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_req_rb_index(mem_req_rb_index),
    .count(count),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Reference model: program-ordered list of pending stores.
  typedef struct {
    int unsigned tag;
    logic [31:0] bv;
    int unsigned bq;
    bit          br;
    logic [31:0] dv;
    int unsigned dq;
    bit          dr;
    logic [31:0] off;
  } st_t;

  st_t mq[$];
  st_t ns;
  bit  m_ret;
  bit  m_acc;

  function automatic logic [31:0] slot(input int unsigned s);
    logic [W*RS-1:0] v;
    v = cdb_data;
    return v[s*W +: W];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      mq.delete();
    end else begin
      m_ret = mq.size() > 0 && mq[0].br && mq[0].dr
              && mem_req_ready;
      m_acc = issue_valid && mq.size() < D;
      foreach (mq[i]) begin
        if (!mq[i].br && cdb_valid[mq[i].bq]) begin
          mq[i].bv = slot(mq[i].bq);
          mq[i].br = 1;
        end
        if (!mq[i].dr && cdb_valid[mq[i].dq]) begin
          mq[i].dv = slot(mq[i].dq);
          mq[i].dr = 1;
        end
      end
      if (m_ret) void'(mq.pop_front());
      if (m_acc) begin
        ns.tag = issue_rb_index;
        ns.off = issue_offset;
        ns.bq  = issue_base_q;
        ns.dq  = issue_data_q;
        ns.br  = issue_base_rdy || cdb_valid[issue_base_q];
        ns.bv  = issue_base_rdy ? issue_base_v
                                : slot(issue_base_q);
        ns.dr  = issue_data_rdy || cdb_valid[issue_data_q];
        ns.dv  = issue_data_rdy ? issue_data_v
                                : slot(issue_data_q);
        mq.push_back(ns);
      end
    end
  end

  bit          e_v;
  logic [31:0] e_a, e_d, e_t;

  always @(negedge clk) begin
    if (!reset) begin
      e_v = mq.size() > 0 && mq[0].br && mq[0].dr;
      e_a = e_v ? mq[0].bv + mq[0].off : 32'd0;
      e_d = e_v ? mq[0].dv : 32'd0;
      e_t = e_v ? mq[0].tag : 32'd0;
      chk("m_issue_ready", 32'(issue_ready),
          32'(mq.size() != D));
      chk("m_valid", 32'(mem_req_valid), 32'(e_v));
      chk("m_addr", mem_req_addr, e_a);
      chk("m_data", mem_req_data, e_d);
      chk("m_rb", 32'(mem_req_rb_index), e_t);
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    issue_valid = 0;
    cdb_valid   = '0;
    flush       = 0;
  endtask

  task automatic issue(input int tag,
                       input logic [31:0] bv, input int bq,
                       input bit br,
                       input logic [31:0] dv, input int dq,
                       input bit dr,
                       input logic [31:0] off);
    issue_valid    = 1;
    issue_rb_index = RI'(tag);
    issue_base_v   = bv;
    issue_base_q   = RI'(bq);
    issue_base_rdy = br;
    issue_data_v   = dv;
    issue_data_q   = RI'(dq);
    issue_data_rdy = dr;
    issue_offset   = off;
  endtask

  task automatic bcast(input int s, input logic [31:0] v);
    cdb_valid[s]       = 1'b1;
    cdb_data[s*W +: W] = v;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, 32'(issue_ready), 32'd1);
    chk({nm, "_valid"}, 32'(mem_req_valid), 32'd0);
    chk({nm, "_addr"}, mem_req_addr, 32'd0);
    chk({nm, "_data"}, mem_req_data, 32'd0);
    chk({nm, "_rb"}, 32'(mem_req_rb_index), 32'd0);
    chk({nm, "_count"}, 32'(count), 32'd0);
    chk({nm, "_empty"}, 32'(empty), 32'd1);
  endtask

  initial begin
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 0;

    // simple fully ready store
    mem_req_ready = 1;
    issue(3, 32'h100, 0, 1, 32'hAB, 0, 1, 32'h8);
    step();
    chk("t1_valid", 32'(mem_req_valid), 32'd1);
    chk("t1_addr", mem_req_addr, 32'h108);
    chk("t1_data", mem_req_data, 32'hAB);
    chk("t1_rb", 32'(mem_req_rb_index), 32'd3);
    step();
    chk("t1_count", 32'(count), 32'd0);

    // base resolved by CDB broadcast
    issue(1, 0, 5, 0, 32'h55, 0, 1, 32'hFFFF_FFFC);
    step();
    step();
    chk("t2_wait", 32'(mem_req_valid), 32'd0);
    bcast(5, 32'h2000);
    step();
    chk("t2_valid", 32'(mem_req_valid), 32'd1);
    chk("t2_addr", mem_req_addr, 32'h1FFC);
    step();

    // fill, overflow attempt, drain with wrap
    mem_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      issue(8 + i, 32'h1000 * (i + 1), 0, 1,
            32'h10 + i, 0, 1, 32'h4);
      step();
    end
    chk("t3_full", 32'(issue_ready), 32'd0);
    chk("t3_count", 32'(count), 32'd4);
    issue(12, 32'h9000, 0, 1, 32'h99, 0, 1, 0);
    step();
    chk("t3_count5", 32'(count), 32'd4);
    chk("t3_hold", mem_req_addr, 32'h1004);
    mem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", 32'(mem_req_rb_index), 32'(8 + i));
      step();
    end
    chk("t3_empty", 32'(empty), 32'd1);

    // head blocks a resolved younger store
    issue(2, 32'h40, 0, 1, 0, 7, 0, 32'h0);
    step();
    issue(4, 32'h80, 0, 1, 32'h44, 0, 1, 32'h0);
    step();
    step();
    chk("t4_block", 32'(mem_req_valid), 32'd0);
    chk("t4_count", 32'(count), 32'd2);
    bcast(7, 32'h77);
    step();
    chk("t4_head", 32'(mem_req_rb_index), 32'd2);
    chk("t4_hdata", mem_req_data, 32'h77);
    step();
    chk("t4_next", 32'(mem_req_rb_index), 32'd4);
    step();
    chk("t4_empty", 32'(empty), 32'd1);

    // capture from CDB in allocation cycle
    issue(6, 32'h300, 0, 1, 0, 9, 0, 32'h10);
    bcast(9, 32'hDEAD);
    step();
    chk("t5_valid", 32'(mem_req_valid), 32'd1);
    chk("t5_data", mem_req_data, 32'hDEAD);
    chk("t5_addr", mem_req_addr, 32'h310);
    step();

    // flush a full queue with a live handshake
    mem_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      issue(i, 32'h20, 0, 1, 32'h1, 0, 1, 32'h0);
      step();
    end
    chk("t6_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1;
    issue(13, 32'h0, 0, 1, 32'h0, 0, 1, 32'h0);
    flush = 1;
    step();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_valid0", 32'(mem_req_valid), 32'd0);
    chk("t6_ready", 32'(issue_ready), 32'd1);

    // asynchronous reset while a store waits
    mem_req_ready = 0;
    issue(5, 32'h500, 0, 1, 32'h5, 0, 1, 32'h0);
    step();
    chk("t7_pre", 32'(mem_req_valid), 32'd1);
    #2 reset = 1;
    #1;
    chk_reset_vals("t7");
    @(negedge clk);
    reset = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
